seg7_scan_controller: RTL and testbench
=======================================

SEG7_SCAN_CONTROLLER -- requirements
Module: seg7_scan_controller

Interface
REQ-001 Parameter NUM_DIGITS, default 4, SHALL set the number of multiplexed digits (2..8).
REQ-002 Parameter SCAN_DIV, default 25000, SHALL set the clock cycles per digit slot (>= 2).
REQ-003 Parameter BLANK_CYCLES, default 250, SHALL set the all-off cycles at each slot start (1..SCAN_DIV-1).
REQ-004 i_Clk  in  1  SHALL be the single clock; all logic is on its rising edge.
REQ-005 i_Rst  in  1  SHALL be the synchronous, active-high reset.
REQ-006 i_Load  in  1  SHALL be a single-cycle request to capture i_Digits.
REQ-007 i_Digits  in  4*NUM_DIGITS  SHALL be the BCD digits; nibble 0 is least significant and maps to slot 0.
REQ-008 i_Lz_Blank  in  1  SHALL enable leading-zero blanking.
REQ-009 o_Digit_Sel  out  NUM_DIGITS  SHALL be the active-low digit enables, at most one low.
REQ-010 o_Segment  out  7  SHALL be the active-low segments, bit0=A .. bit6=G.
REQ-011 o_Load_Ack  out  1  SHALL pulse high for one cycle when a captured value becomes displayed.
REQ-012 o_Frame_Start  out  1  SHALL pulse high for one cycle on the first BLANK cycle of slot 0.

Function
REQ-013 The FSM SHALL have exactly two states, BLANK and DRIVE, and a slot counter of 0..SCAN_DIV-1.
REQ-014 BLANK SHALL hold for BLANK_CYCLES cycles, with o_Digit_Sel all ones and o_Segment 7'h7F.
REQ-015 DRIVE SHALL hold for SCAN_DIV-BLANK_CYCLES cycles, with only bit [idx] of o_Digit_Sel low.
REQ-016 At the end of DRIVE, idx SHALL increment, wrap from NUM_DIGITS-1 to 0, and the FSM SHALL enter BLANK.
REQ-017 A full frame SHALL be exactly NUM_DIGITS*SCAN_DIV cycles, with no gaps.
REQ-018 o_Segment and o_Digit_Sel SHALL be registered and change on the same edge, so there is no skew.
REQ-019 The decode SHALL be from the active register. Codes 0-9 SHALL give standard glyphs; codes 10-15 SHALL give "-" (7'b0111111).
REQ-020 With i_Lz_Blank=1, a zero digit SHALL show 7'h7F while all more-significant digits are zero; digit 0 SHALL never be blanked.
REQ-021 i_Load=1 SHALL copy i_Digits into the shadow register and set pending. Multiple loads before a commit: the last one wins, with a single ack.
REQ-022 Commit (shadow->active, clear pending, o_Load_Ack=1) SHALL occur only in the cycle o_Frame_Start=1 and only if pending=1, so frames never tear.
REQ-023 If i_Load coincides with the commit cycle, the commit SHALL use the prior shadow value. The new value SHALL be captured, pending SHALL remain set, and it SHALL commit at the next frame.
REQ-024 Changing i_Lz_Blank mid-frame SHALL take effect at the next DRIVE entry.

Reset
REQ-025 i_Rst SHALL set state=BLANK, counter=0, idx=0, active=0, shadow=0, and pending=0.
REQ-026 During and after reset, until the first DRIVE, o_Digit_Sel SHALL be all ones, o_Segment=7'h7F, and o_Load_Ack=0.
REQ-027 The first cycle after reset release SHALL assert o_Frame_Start=1.
REQ-028 Reset asserted mid-frame SHALL abort the scan immediately and discard pending loads, with no ack.

Structure
REQ-029 A shared package seg7_pkg SHALL hold the FSM state typedef, the 7-bit glyph constants (0-9, dash, off), and the default parameter values.
REQ-030 There SHALL be one combinational sub-module, seg7_glyph_decode (4-bit code + blank flag -> 7-bit active-low pattern), instantiated once and shared across all digits.
REQ-031 The top SHALL contain the FSM, counters, shadow/active registers, LZ-blank mask logic, and output registers.

Verification (NUM_DIGITS=4, SCAN_DIV=8, BLANK_CYCLES=2)
REQ-032 Reset release -> o_Frame_Start at cycle 0, then slot 0:
- o_Digit_Sel=4'b1111 for cycles 0-1.
- o_Digit_Sel=4'b1110 for cycles 2-7.
- Slot 1 starts at cycle 8.
- The next o_Frame_Start is at cycle 32.
REQ-033 Load 16'h4321 mid-frame -> no display change until the next o_Frame_Start, then o_Load_Ack for exactly 1 cycle. Slot 0 then shows 7'b1111001 ("1"), and slot 3 shows "4".
REQ-034 Load 16'h0007 with i_Lz_Blank=1 -> slots 3..1 show 7'h7F and slot 0 shows "7". With i_Lz_Blank=0 -> slots 3..1 show 7'b1000000.
REQ-035 Load 16'hA000 in the commit cycle of a pending 16'h1111 -> 1111 is displayed with 1 ack; the next frame displays "-000" with a 2nd ack.
REQ-036 Assert i_Rst during slot 2 DRIVE with a load pending -> next cycle o_Digit_Sel=4'b1111, active=0, no o_Load_Ack ever for that load.
REQ-037 Every cycle: o_Digit_Sel has at most one zero, and o_Segment=7'h7F whenever o_Digit_Sel is all ones.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared definitions for the multiplexed seven-segment scan controller.
//   - scan_state_t : two-state scan FSM encoding (BLANK / DRIVE)
//   - GLYPH_*      : 7-bit active-low segment patterns, bit0=A .. bit6=G
//   - DEF_*        : default values for the controller parameters
package seg7_pkg;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } scan_state_t;

  localparam logic [6:0] GLYPH_0    = 7'b1000000;
  localparam logic [6:0] GLYPH_1    = 7'b1111001;
  localparam logic [6:0] GLYPH_2    = 7'b0100100;
  localparam logic [6:0] GLYPH_3    = 7'b0110000;
  localparam logic [6:0] GLYPH_4    = 7'b0011001;
  localparam logic [6:0] GLYPH_5    = 7'b0010010;
  localparam logic [6:0] GLYPH_6    = 7'b0000010;
  localparam logic [6:0] GLYPH_7    = 7'b1111000;
  localparam logic [6:0] GLYPH_8    = 7'b0000000;
  localparam logic [6:0] GLYPH_9    = 7'b0010000;
  localparam logic [6:0] GLYPH_DASH = 7'b0111111;
  localparam logic [6:0] GLYPH_OFF  = 7'b1111111;

  localparam int DEF_NUM_DIGITS   = 4;
  localparam int DEF_SCAN_DIV     = 25000;
  localparam int DEF_BLANK_CYCLES = 250;

endpackage

// File: rtl/seg7_glyph_decode.sv
// Combinational BCD-to-seven-segment decoder (active-low outputs).
//   code    : 4-bit digit code; 0-9 give numerals, 10-15 give a dash
//   blank   : forces all segments off (leading-zero suppression)
//   segment : active-low pattern, bit0=A .. bit6=G
module seg7_glyph_decode
  import seg7_pkg::*;
(
  input  logic [3:0] code,
  input  logic       blank,
  output logic [6:0] segment
);

  always_comb begin
    segment = GLYPH_DASH;
    if (blank) begin
      segment = GLYPH_OFF;
    end else begin
      case (code)
        4'd0:    segment = GLYPH_0;
        4'd1:    segment = GLYPH_1;
        4'd2:    segment = GLYPH_2;
        4'd3:    segment = GLYPH_3;
        4'd4:    segment = GLYPH_4;
        4'd5:    segment = GLYPH_5;
        4'd6:    segment = GLYPH_6;
        4'd7:    segment = GLYPH_7;
        4'd8:    segment = GLYPH_8;
        4'd9:    segment = GLYPH_9;
        default: segment = GLYPH_DASH;
      endcase
    end
  end

endmodule

// File: rtl/seg7_scan_controller.sv
// Time-multiplexed seven-segment display scanner with tear-free updates.
// Each digit slot lasts SCAN_DIV cycles: BLANK_CYCLES with everything off
// (ghosting guard), then the rest driving one digit. New values are staged
// in a shadow register and only promoted to the displayed (active) register
// at the start of a frame.
//   i_Clk         : clock, rising edge
//   i_Rst         : synchronous active-high reset
//   i_Load        : single-cycle capture strobe for i_Digits
//   i_Digits      : BCD digits, nibble 0 = least significant = slot 0
//   i_Lz_Blank    : leading-zero blanking enable
//   o_Digit_Sel   : active-low digit enables (at most one low)
//   o_Segment     : active-low segments, bit0=A .. bit6=G
//   o_Load_Ack    : one-cycle pulse in the cycle a staged value is committed
//   o_Frame_Start : one-cycle pulse on the first BLANK cycle of slot 0
module seg7_scan_controller
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = DEF_NUM_DIGITS,
  parameter int SCAN_DIV     = DEF_SCAN_DIV,
  parameter int BLANK_CYCLES = DEF_BLANK_CYCLES
) (
  input  logic                    i_Clk,
  input  logic                    i_Rst,
  input  logic                    i_Load,
  input  logic [4*NUM_DIGITS-1:0] i_Digits,
  input  logic                    i_Lz_Blank,
  output logic [NUM_DIGITS-1:0]   o_Digit_Sel,
  output logic [6:0]              o_Segment,
  output logic                    o_Load_Ack,
  output logic                    o_Frame_Start
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam int IDX_W = $clog2(NUM_DIGITS);

  scan_state_t             state;
  logic [CNT_W-1:0]        cnt;
  logic [IDX_W-1:0]        idx;
  logic [4*NUM_DIGITS-1:0] active;
  logic [4*NUM_DIGITS-1:0] shadow;
  logic                    pending;

  logic [NUM_DIGITS-1:0]   sel_p1;
  logic [6:0]              seg_p1;
  logic                    fs_p1;
  logic                    ack_p1;

  scan_state_t             state_nxt;
  logic [CNT_W-1:0]        cnt_nxt;
  logic [IDX_W-1:0]        idx_nxt;
  logic [4*NUM_DIGITS-1:0] active_nxt;
  logic                    pending_nxt;
  logic                    slot_end;
  logic                    blank_end;
  logic                    commit;
  logic                    fs_nxt;
  logic                    ack_nxt;
  logic [NUM_DIGITS-1:0]   lz_mask;
  logic                    zero_above;
  logic [3:0]              dec_code;
  logic                    dec_blank;
  logic [6:0]              dec_seg;

  // ---- next-state / slot sequencing ----
  always_comb begin
    slot_end  = (cnt == CNT_W'(SCAN_DIV - 1));
    blank_end = (cnt == CNT_W'(BLANK_CYCLES - 1));
    cnt_nxt   = slot_end ? '0 : cnt + 1'b1;
    idx_nxt   = idx;
    if (slot_end) begin
      idx_nxt = (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
    end
    state_nxt = state;
    case (state)
      ST_BLANK: if (blank_end) state_nxt = ST_DRIVE;
      ST_DRIVE: if (slot_end)  state_nxt = ST_BLANK;
      default:  state_nxt = ST_BLANK;
    endcase
    fs_nxt = (state_nxt == ST_BLANK) && (cnt_nxt == '0) && (idx_nxt == '0);
  end

  // ---- shadow/active commit ----
  // The commit happens at the edge that ends the frame-start cycle, so a load
  // landing in that same cycle is staged for the following frame while the
  // older shadow value is promoted. The ack is registered one edge early so
  // it is visible during the frame-start cycle itself.
  always_comb begin
    commit      = fs_p1 && pending;
    active_nxt  = commit ? shadow : active;
    pending_nxt = i_Load || (pending && !commit);
    ack_nxt     = fs_nxt && pending_nxt;
  end

  // ---- leading-zero mask and shared decode ----
  // Decode uses active_nxt so a digit entering DRIVE on the commit edge
  // already shows the newly committed value.
  always_comb begin
    zero_above = 1'b1;
    lz_mask    = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      lz_mask[i] = i_Lz_Blank && zero_above && (active_nxt[4*i +: 4] == 4'd0) && (i != 0);
      zero_above = zero_above && (active_nxt[4*i +: 4] == 4'd0);
    end
    dec_code  = active_nxt[4*int'(idx_nxt) +: 4];
    dec_blank = lz_mask[idx_nxt];
  end

  seg7_glyph_decode u_decode (
    .code    (dec_code),
    .blank   (dec_blank),
    .segment (dec_seg)
  );

  // ---- registered state and outputs ----
  // Outputs are computed from next-state values so they line up with the
  // state register. Segments are latched only on DRIVE entry, which makes an
  // i_Lz_Blank change wait for the next slot.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state   <= ST_BLANK;
      cnt     <= '0;
      idx     <= '0;
      active  <= '0;
      shadow  <= '0;
      pending <= 1'b0;
      sel_p1  <= '1;
      seg_p1  <= GLYPH_OFF;
      fs_p1   <= 1'b1;
      ack_p1  <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      idx     <= idx_nxt;
      active  <= active_nxt;
      pending <= pending_nxt;
      fs_p1   <= fs_nxt;
      ack_p1  <= ack_nxt;
      if (i_Load) begin
        shadow <= i_Digits;
      end
      if (state_nxt == ST_BLANK) begin
        sel_p1 <= '1;
        seg_p1 <= GLYPH_OFF;
      end else if (state == ST_BLANK) begin
        sel_p1 <= ~(NUM_DIGITS'(1) << idx_nxt);
        seg_p1 <= dec_seg;
      end
    end
  end

  assign o_Digit_Sel   = sel_p1;
  assign o_Segment     = seg_p1;
  assign o_Load_Ack    = ack_p1;
  assign o_Frame_Start = fs_p1;

endmodule

// File: tb/tb_seg7_scan_controller.sv
// Directed bench for seg7_scan_controller with NUM_DIGITS=4, SCAN_DIV=8,
// BLANK_CYCLES=2. Inputs change and outputs are sampled on the falling edge;
// "cycle 0" is the first cycle after reset release.
module tb_seg7_scan_controller;

  localparam int ND = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          load = 1'b0;
  logic [4*ND-1:0] digits = '0;
  logic          lz = 1'b0;
  logic [ND-1:0] sel;
  logic [6:0]    seg;
  logic          ack;
  logic          fs;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  localparam logic [6:0] G0   = 7'b1000000;
  localparam logic [6:0] G1   = 7'b1111001;
  localparam logic [6:0] G2   = 7'b0100100;
  localparam logic [6:0] G4   = 7'b0011001;
  localparam logic [6:0] G7   = 7'b1111000;
  localparam logic [6:0] GDSH = 7'b0111111;
  localparam logic [6:0] GOFF = 7'h7F;

  seg7_scan_controller #(
    .NUM_DIGITS   (ND),
    .SCAN_DIV     (8),
    .BLANK_CYCLES (2)
  ) dut (
    .i_Clk         (clk),
    .i_Rst         (rst),
    .i_Load        (load),
    .i_Digits      (digits),
    .i_Lz_Blank    (lz),
    .o_Digit_Sel   (sel),
    .o_Segment     (seg),
    .o_Load_Ack    (ack),
    .o_Frame_Start (fs)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s @cyc %0d: observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    chk("one_hot_sel", 32'($countones(~sel) <= 1), 32'd1);
    chk("off_when_idle", 32'((sel != '1) || (seg == GOFF)), 32'd1);
  endtask

  task automatic go_to(input int target);
    while (cyc < target) tick();
  endtask

  task automatic do_load(input logic [4*ND-1:0] d);
    load   = 1'b1;
    digits = d;
    tick();
    load   = 1'b0;
  endtask

  task automatic chk_out(input string tag, input logic [ND-1:0] s, input logic [6:0] g);
    chk({tag, "_sel"}, 32'(sel), 32'(s));
    chk({tag, "_seg"}, 32'(seg), 32'(g));
  endtask

  initial begin
    // Reset state
    repeat (3) tick();
    chk_out("rst", 4'b1111, GOFF);
    chk("rst_ack", 32'(ack), 32'd0);
    rst = 1'b0;
    cyc = 0;

    // Basic scan timing
    chk("fs_c0", 32'(fs), 32'd1);
    chk("ack_c0", 32'(ack), 32'd0);
    chk_out("c0", 4'b1111, GOFF);
    go_to(1);  chk_out("c1", 4'b1111, GOFF); chk("fs_c1", 32'(fs), 32'd0);
    go_to(2);  chk_out("c2", 4'b1110, G0);
    go_to(7);  chk_out("c7", 4'b1110, G0);
    go_to(8);  chk_out("c8", 4'b1111, GOFF);
    go_to(10); chk_out("c10", 4'b1101, G0);
    go_to(31); chk("fs_c31", 32'(fs), 32'd0);
    go_to(32); chk("fs_c32", 32'(fs), 32'd1);

    // Mid-frame loads: last one wins, display unchanged until frame start
    go_to(34); do_load(16'h9999);
    go_to(36); do_load(16'h4321);
    go_to(42); chk_out("pre_commit", 4'b1101, G0);
    go_to(63); chk("ack_c63", 32'(ack), 32'd0);
    go_to(64); chk("fs_c64", 32'(fs), 32'd1); chk("ack_c64", 32'(ack), 32'd1);
    go_to(65); chk("ack_c65", 32'(ack), 32'd0);
    go_to(66); chk_out("s0_4321", 4'b1110, G1);
    go_to(74); chk_out("s1_4321", 4'b1101, G2);

    // Leading-zero blanking
    go_to(70); lz = 1'b1; do_load(16'h0007);
    go_to(90); chk_out("s3_4321", 4'b0111, G4);
    go_to(96); chk("ack_c96", 32'(ack), 32'd1);
    go_to(98);  chk_out("lz_s0", 4'b1110, G7);
    go_to(106); chk_out("lz_s1", 4'b1101, GOFF);
    go_to(114); chk_out("lz_s2", 4'b1011, GOFF);
    go_to(122); chk_out("lz_s3", 4'b0111, GOFF);
    go_to(124); lz = 1'b0;
    go_to(125); chk_out("lz_hold", 4'b0111, GOFF);
    go_to(130); chk_out("nolz_s0", 4'b1110, G7);
    go_to(138); chk_out("nolz_s1", 4'b1101, G0);

    // Load colliding with the commit cycle
    go_to(140); do_load(16'h1111);
    go_to(154); chk_out("nolz_s3", 4'b0111, G0);
    go_to(160); chk("fs_c160", 32'(fs), 32'd1); chk("ack_c160", 32'(ack), 32'd1);
    do_load(16'hA000);
    chk("ack_c161", 32'(ack), 32'd0);
    go_to(162); chk_out("s0_1111", 4'b1110, G1);
    go_to(186); chk_out("s3_1111", 4'b0111, G1);
    go_to(191); chk("ack_c191", 32'(ack), 32'd0);
    go_to(192); chk("ack_c192", 32'(ack), 32'd1);
    go_to(193); chk("ack_c193", 32'(ack), 32'd0);
    go_to(194); chk_out("s0_A000", 4'b1110, G0);
    go_to(218); chk_out("s3_A000", 4'b0111, GDSH);

    // Reset during slot 2 DRIVE with a load pending
    go_to(226); do_load(16'h5555);
    go_to(243); chk_out("pre_rst", 4'b1011, G0);
    rst = 1'b1;
    tick();
    chk_out("mid_rst", 4'b1111, GOFF);
    chk("mid_rst_ack", 32'(ack), 32'd0);
    tick();
    rst = 1'b0;
    cyc = 0;
    chk("fs_r0", 32'(fs), 32'd1);
    chk("ack_r0", 32'(ack), 32'd0);
    go_to(2);  chk_out("r_s0", 4'b1110, G0);
    go_to(26); chk_out("r_s3", 4'b0111, G0);
    go_to(32); chk("fs_r32", 32'(fs), 32'd1); chk("ack_r32", 32'(ack), 32'd0);
    go_to(34); chk_out("r2_s0", 4'b1110, G0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
